// File: rtl/sd_spi.sv
// SD-card SPI master (mode 0, MSB first): CPU writes bytes out, MISO bytes land in an RX FIFO.
// Latency: 16*(DIV+1) cycles per byte from leaving IDLE to the push; interrupt lags rx_cnt by 1 cycle.
// Backpressure: none on the bus; a write with a byte still pending or a push into a full FIFO is dropped and sets ovf.
module sd_spi #(
  parameter int DEPTH = 4,
  parameter int DIV_W = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] io_addr,
  input  logic       io_write,
  input  logic       io_read,
  input  logic [7:0] io_wdata,
  output logic [7:0] io_rdata,
  output logic       interrupt,
  output logic       sclk,
  output logic       mosi,
  input  logic       miso,
  output logic       cs_n
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, LO, HI} state_t;

  state_t           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d, cnt_q, cnt_d;
  logic [7:0]       hold_q, hold_d, shift_q, shift_d;
  logic [2:0]       bit_q, bit_d;
  logic             txv_q, txv_d, ovf_q, ovf_d, ien_q, ien_d, cs_q, cs_d;
  logic             sclk_q, sclk_d, mosi_q, mosi_d, int_q, int_d;

  logic [7:0]       mem_q [DEPTH];
  logic [7:0]       mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    rx_cnt_q, rx_cnt_d;

  logic wr_data, wr_stat, wr_div, rd_data;
  logic consume, push, push_ok, pop, fifo_empty, fifo_full, busy;
  logic [2:0] rx_cnt3;

  assign wr_data    = io_write && (io_addr == 4'd0);
  assign wr_stat    = io_write && (io_addr == 4'd1);
  assign wr_div     = io_write && (io_addr == 4'd2);
  assign rd_data    = io_read  && (io_addr == 4'd0);
  assign fifo_empty = (rx_cnt_q == '0);
  assign fifo_full  = (rx_cnt_q == CW'(DEPTH));
  assign pop        = rd_data && !fifo_empty;
  assign busy       = (state_q != IDLE);
  assign rx_cnt3    = 3'(rx_cnt_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    sclk_d  = sclk_q;
    mosi_d  = mosi_q;
    consume = 1'b0;
    push    = 1'b0;
    case (state_q)
      IDLE: begin
        sclk_d = 1'b0;
        if (txv_q) consume = 1'b1;
      end
      LO: begin
        if (cnt_q == '0) begin
          sclk_d  = 1'b1;
          shift_d = {shift_q[6:0], miso};
          cnt_d   = div_q;
          state_d = HI;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      HI: begin
        if (cnt_q == '0) begin
          sclk_d = 1'b0;
          if (bit_q == 3'd7) begin
            push = 1'b1;
            if (txv_q) consume = 1'b1;
            else       state_d = IDLE;
          end else begin
            bit_d   = bit_q + 3'd1;
            mosi_d  = shift_q[7];
            cnt_d   = div_q;
            state_d = LO;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // Loading from IDLE and the gapless reload at the end of HI share one path.
    if (consume) begin
      shift_d = hold_q;
      mosi_d  = hold_q[7];
      bit_d   = 3'd0;
      cnt_d   = div_q;
      state_d = LO;
    end

    hold_d = hold_q;
    txv_d  = txv_q & ~consume;
    ovf_d  = ovf_q;
    ien_d  = ien_q;
    cs_d   = cs_q;
    div_d  = div_q;
    if (wr_stat) begin
      ien_d = io_wdata[1];
      cs_d  = io_wdata[0];
      if (io_wdata[4]) ovf_d = 1'b0;
    end
    if (wr_div) div_d = DIV_W'(io_wdata);
    if (wr_data) begin
      if (txv_q && !consume) begin
        ovf_d = 1'b1;
      end else begin
        hold_d = io_wdata;
        txv_d  = 1'b1;
      end
    end
    if (push && fifo_full && !pop) ovf_d = 1'b1;
    int_d = ien_q && !fifo_empty;
  end

  // A full FIFO still accepts a push when the same cycle pops the head.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    rx_cnt_d = rx_cnt_q;
    push_ok  = push && (!fifo_full || pop);
    if (push_ok) begin
      mem_d[wr_ptr_q] = shift_q;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    if (push_ok && !pop)      rx_cnt_d = rx_cnt_q + 1'b1;
    else if (!push_ok && pop) rx_cnt_d = rx_cnt_q - 1'b1;
  end

  always_comb begin
    io_rdata = 8'h00;
    case (io_addr)
      4'd0:    io_rdata = fifo_empty ? 8'hFF : mem_q[rd_ptr_q];
      4'd1:    io_rdata = {rx_cnt3, ovf_q, busy, txv_q, ien_q, cs_q};
      4'd2:    io_rdata = 8'(div_q);
      default: io_rdata = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      hold_q   <= '0;
      txv_q    <= 1'b0;
      ovf_q    <= 1'b0;
      ien_q    <= 1'b0;
      cs_q     <= 1'b0;
      div_q    <= '1;
      sclk_q   <= 1'b0;
      mosi_q   <= 1'b1;
      int_q    <= 1'b0;
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      rx_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      hold_q   <= hold_d;
      txv_q    <= txv_d;
      ovf_q    <= ovf_d;
      ien_q    <= ien_d;
      cs_q     <= cs_d;
      div_q    <= div_d;
      sclk_q   <= sclk_d;
      mosi_q   <= mosi_d;
      int_q    <= int_d;
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      rx_cnt_q <= rx_cnt_d;
    end
  end

  assign sclk      = sclk_q;
  assign mosi      = mosi_q;
  assign cs_n      = ~cs_q;
  assign interrupt = int_q;

endmodule

// File: tb/tb_sd_spi.sv
// Directed bench for sd_spi: register table plus hand-timed transfer sequences.
module tb_sd_spi;
  logic       clk, reset;
  logic [3:0] io_addr;
  logic       io_write, io_read;
  logic [7:0] io_wdata, io_rdata;
  logic       interrupt, sclk, mosi, miso, cs_n;
  logic       loop_en, miso_v;

  assign miso = loop_en ? mosi : miso_v;

  sd_spi dut (
    .clk(clk), .reset(reset), .io_addr(io_addr), .io_write(io_write), .io_read(io_read),
    .io_wdata(io_wdata), .io_rdata(io_rdata), .interrupt(interrupt), .sclk(sclk),
    .mosi(mosi), .miso(miso), .cs_n(cs_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp, n_err;

  typedef struct {
    logic       wr;
    logic [3:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp;
    logic       exp_cs_n;
  } vec_t;
  vec_t tbl[18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    io_addr = a; io_wdata = d; io_write = 1'b1;
    @(negedge clk);
    io_write = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a, output logic [7:0] d);
    io_addr = a; io_read = 1'b1;
    #1 d = io_rdata;
    @(negedge clk);
    io_read = 1'b0;
  endtask

  task automatic rd_chk(input string name, input logic [3:0] a, input logic [7:0] exp);
    logic [7:0] d;
    rd(a, d);
    chk(name, 32'(d), 32'(exp));
  endtask

  // Advance one cycle while reading STAT (side-effect free), sampling after the edge.
  task automatic step(output logic [7:0] s);
    io_addr = 4'd1; io_read = 1'b1;
    @(negedge clk);
    #1 s = io_rdata;
  endtask

  task automatic wait_idle(input string name);
    logic [7:0] s;
    int n = 0;
    s = 8'h0C;
    while ((s[3] || s[2]) && n < 400) begin
      rd(4'd1, s);
      n++;
    end
    chk(name, 32'(s[3:2]), 32'd0);
  endtask

  task automatic send(input logic [7:0] b);
    wr(4'd0, b);
    wait_idle("send_idle");
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  s, d;
    logic [16:0] sc;
    logic [15:0] tx;
    logic [7:0]  rxb;
    logic [7:0]  t3_stat[4];
    logic        prev;
    int          nidle, nrise;

    n_cmp = 0; n_err = 0;
    io_addr = 4'd0; io_write = 1'b0; io_read = 1'b0; io_wdata = 8'h00;
    loop_en = 1'b0; miso_v = 1'b0;

    tbl[0]  = '{1'b0, 4'h1, 8'h00, 8'h00, 1'b1};
    tbl[1]  = '{1'b0, 4'h2, 8'h00, 8'hFF, 1'b1};
    tbl[2]  = '{1'b0, 4'h0, 8'h00, 8'hFF, 1'b1};
    tbl[3]  = '{1'b0, 4'h3, 8'h00, 8'h00, 1'b1};
    tbl[4]  = '{1'b0, 4'hF, 8'h00, 8'h00, 1'b1};
    tbl[5]  = '{1'b1, 4'h2, 8'h5A, 8'h00, 1'b1};
    tbl[6]  = '{1'b0, 4'h2, 8'h00, 8'h5A, 1'b1};
    tbl[7]  = '{1'b1, 4'h3, 8'h77, 8'h00, 1'b1};
    tbl[8]  = '{1'b0, 4'h2, 8'h00, 8'h5A, 1'b1};
    tbl[9]  = '{1'b0, 4'h1, 8'h00, 8'h00, 1'b1};
    tbl[10] = '{1'b1, 4'h1, 8'h03, 8'h00, 1'b0};
    tbl[11] = '{1'b0, 4'h1, 8'h00, 8'h03, 1'b0};
    tbl[12] = '{1'b1, 4'h1, 8'hFE, 8'h00, 1'b1};
    tbl[13] = '{1'b0, 4'h1, 8'h00, 8'h02, 1'b1};
    tbl[14] = '{1'b1, 4'h1, 8'h01, 8'h00, 1'b0};
    tbl[15] = '{1'b0, 4'h1, 8'h00, 8'h01, 1'b0};
    tbl[16] = '{1'b1, 4'h2, 8'h00, 8'h00, 1'b0};
    tbl[17] = '{1'b0, 4'h2, 8'h00, 8'h00, 1'b0};
    t3_stat[0] = 8'h71; t3_stat[1] = 8'h51; t3_stat[2] = 8'h31; t3_stat[3] = 8'h11;

    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_sclk", 32'(sclk), 32'd0);
    chk("rst_mosi", 32'(mosi), 32'd1);
    chk("rst_cs_n", 32'(cs_n), 32'd1);
    chk("rst_int", 32'(interrupt), 32'd0);
    reset = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 18; i++) begin
      if (tbl[i].wr) begin
        wr(tbl[i].addr, tbl[i].wdata);
      end else begin
        rd(tbl[i].addr, d);
        chk($sformatf("tbl%0d_rd", i), 32'(d), 32'(tbl[i].exp));
      end
      chk($sformatf("tbl%0d_cs_n", i), 32'(cs_n), 32'(tbl[i].exp_cs_n));
    end

    // Loopback byte at DIV=0: 2-cycle SCLK, push 16 cycles after leaving IDLE.
    loop_en = 1'b1;
    wr(4'd0, 8'hA5);
    sc = '0; rxb = '0;
    for (int k = 1; k <= 17; k++) begin
      step(s);
      sc[k-1] = sclk;
      if (sclk) rxb = {rxb[6:0], mosi};
      if (k == 16) chk("t1_cnt_at16", 32'(s[7:5]), 32'd0);
      if (k == 17) chk("t1_cnt_at17", 32'(s[7:5]), 32'd1);
    end
    io_read = 1'b0;
    chk("t1_sclk", 32'(sc), 32'h0AAAA);
    chk("t1_mosi", 32'(rxb), 32'hA5);
    rd_chk("t1_stat", 4'd1, 8'h21);
    rd_chk("t1_data", 4'd0, 8'hA5);
    rd_chk("t1_stat2", 4'd1, 8'h01);

    // Back-to-back bytes at DIV=3; second write lands on the consume cycle.
    loop_en = 1'b0; miso_v = 1'b0;
    wr(4'd2, 8'h03);
    wr(4'd0, 8'h3C);
    wr(4'd0, 8'hC3);
    nidle = 0; nrise = 0; tx = '0; prev = 1'b0;
    for (int k = 2; k <= 128; k++) begin
      step(s);
      if (!s[3]) nidle++;
      if (sclk && !prev) begin
        tx = {tx[14:0], mosi};
        nrise++;
      end
      prev = sclk;
    end
    step(s);
    io_read = 1'b0;
    chk("t2_idle_gaps", 32'(nidle), 32'd0);
    chk("t2_rises", 32'(nrise), 32'd16);
    chk("t2_mosi", 32'(tx), 32'h3CC3);
    chk("t2_stat_end", 32'(s), 32'h41);
    rd_chk("t2_data0", 4'd0, 8'h00);
    rd_chk("t2_data1", 4'd0, 8'h00);
    rd_chk("t2_data2", 4'd0, 8'hFF);
    rd_chk("t2_stat", 4'd1, 8'h01);

    // FIFO overflow with miso=1.
    wr(4'd2, 8'h00);
    miso_v = 1'b1;
    for (int i = 0; i < 4; i++) send(8'h00);
    rd_chk("t3_full", 4'd1, 8'h81);
    send(8'h00);
    rd_chk("t3_ovf", 4'd1, 8'h91);
    for (int i = 0; i < 4; i++) begin
      rd_chk($sformatf("t3_data%0d", i), 4'd0, 8'hFF);
      rd_chk($sformatf("t3_stat%0d", i), 4'd1, t3_stat[i]);
    end
    rd_chk("t3_empty_data", 4'd0, 8'hFF);
    rd_chk("t3_empty_stat", 4'd1, 8'h11);
    wr(4'd1, 8'h11);
    rd_chk("t3_ovf_clr", 4'd1, 8'h01);

    // Push and pop in the same cycle while full.
    miso_v = 1'b0;
    for (int i = 0; i < 4; i++) send(8'h00);
    rd_chk("t3b_full", 4'd1, 8'h81);
    miso_v = 1'b1;
    wr(4'd0, 8'h00);
    repeat (16) @(negedge clk);
    rd_chk("t3b_pp_data", 4'd0, 8'h00);
    rd_chk("t3b_pp_stat", 4'd1, 8'h81);
    rd_chk("t3b_d0", 4'd0, 8'h00);
    rd_chk("t3b_d1", 4'd0, 8'h00);
    rd_chk("t3b_d2", 4'd0, 8'h00);
    rd_chk("t3b_d3", 4'd0, 8'hFF);
    rd_chk("t3b_stat", 4'd1, 8'h01);

    // Interrupt timing.
    wr(4'd1, 8'h03);
    wr(4'd0, 8'h00);
    for (int k = 1; k <= 18; k++) begin
      step(s);
      if (k == 17) chk("t4_int_at_push", 32'(interrupt), 32'd0);
      if (k == 18) chk("t4_int_after", 32'(interrupt), 32'd1);
    end
    io_read = 1'b0;
    rd_chk("t4_data", 4'd0, 8'hFF);
    chk("t4_int_lag", 32'(interrupt), 32'd1);
    @(negedge clk);
    chk("t4_int_fall", 32'(interrupt), 32'd0);
    wr(4'd1, 8'h01);
    send(8'h00);
    repeat (3) @(negedge clk);
    chk("t4_int_masked", 32'(interrupt), 32'd0);
    rd_chk("t4_data2", 4'd0, 8'hFF);

    // Double write while busy: second one dropped.
    wr(4'd2, 8'h03);
    loop_en = 1'b1;
    wr(4'd0, 8'h11);
    @(negedge clk);
    wr(4'd0, 8'h22);
    wr(4'd0, 8'h33);
    rd_chk("t5_stat_busy", 4'd1, 8'h1D);
    wait_idle("t5_idle");
    rd_chk("t5_stat_done", 4'd1, 8'h51);
    wr(4'd1, 8'h11);
    rd_chk("t5_stat_clr", 4'd1, 8'h41);
    rd_chk("t5_data0", 4'd0, 8'h11);
    rd_chk("t5_data1", 4'd0, 8'h22);
    rd_chk("t5_data2", 4'd0, 8'hFF);

    // Reset during bit 3 of a transfer.
    loop_en = 1'b0; miso_v = 1'b1;
    wr(4'd2, 8'h01);
    wr(4'd1, 8'h03);
    send(8'h00);
    repeat (2) @(negedge clk);
    chk("t6_pre_int", 32'(interrupt), 32'd1);
    wr(4'd0, 8'h00);
    repeat (13) @(negedge clk);
    chk("t6_pre_mosi", 32'(mosi), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    chk("t6_sclk", 32'(sclk), 32'd0);
    chk("t6_cs_n", 32'(cs_n), 32'd1);
    chk("t6_mosi", 32'(mosi), 32'd1);
    chk("t6_int", 32'(interrupt), 32'd0);
    rd_chk("t6_stat", 4'd1, 8'h00);
    rd_chk("t6_div", 4'd2, 8'hFF);
    rd_chk("t6_data", 4'd0, 8'hFF);
    repeat (40) @(negedge clk);
    rd_chk("t6_stat_late", 4'd1, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
